// File: rtl/xrv_mem_arb.sv
// xrv_mem_arb: single-port memory arbiter for the xriscv core.
// Shares one memory bus between instruction fetch and the load/store unit,
// one transaction at a time. Load/store wins by default; a starvation counter
// forces a fetch through after STARVE_MAX consecutive data grants taken while
// a fetch was waiting. A flush discards the response of an in-flight fetch
// without withdrawing the bus request that is already out.
module xrv_mem_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ls_hint,
    input  logic        flush,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_be,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic        busy,
    output logic        err
);

    localparam int             CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]  STARVE_TOP = CW'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE,
        IF_PEND,
        IF_RESP,
        LS_PEND,
        LS_RESP
    } state_t;

    state_t         state;
    logic           drop;
    logic [CW-1:0]  starve_cnt;

    logic           starved;
    logic           fetch_go;
    logic           in_resp;

    // A waiting fetch wins when starved; otherwise only when no data request
    // is present and neither the decoder hint nor a flush holds it off.
    assign starved  = (starve_cnt == STARVE_TOP);
    assign fetch_go = if_req && (starved || (!ls_req && !ls_hint && !flush));
    assign in_resp  = (state == IF_RESP) || (state == LS_RESP);

    // Handshake outputs decoded straight from state and the bus signals.
    assign if_gnt    = mem_gnt && (state == IF_PEND);
    assign ls_gnt    = mem_gnt && (state == LS_PEND);
    assign if_rvalid = mem_rvalid && (state == IF_RESP) && !drop && !flush;
    assign ls_rvalid = mem_rvalid && (state == LS_RESP);
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;
    assign busy      = (state != IDLE);

    // Arbitration FSM with registered bus request, drop/starvation tracking and sticky error.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every branch
        // below reads the values from before this clock edge.
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'h0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            drop       <= 1'b0;
            starve_cnt <= '0;
            err        <= 1'b0;
        end else begin
            // A response with no transaction waiting for it is a protocol fault.
            if (mem_rvalid && !in_resp) begin
                err <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (fetch_go) begin
                        state      <= IF_PEND;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_be     <= 4'hF;
                        mem_addr   <= if_addr;
                        mem_wdata  <= 32'h0;
                        starve_cnt <= '0;
                    end else if (ls_req) begin
                        state     <= LS_PEND;
                        mem_req   <= 1'b1;
                        mem_we    <= ls_we;
                        mem_be    <= ls_be;
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wdata;
                        if (if_req && !starved) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end

                IF_PEND: begin
                    if (flush) begin
                        drop <= 1'b1;
                    end
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= IF_RESP;
                    end
                end

                IF_RESP: begin
                    if (flush) begin
                        drop <= 1'b1;
                    end
                    // Leaving for IDLE clears drop, overriding a same-cycle flush.
                    if (mem_rvalid) begin
                        drop  <= 1'b0;
                        state <= IDLE;
                    end
                end

                LS_PEND: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= LS_RESP;
                    end
                end

                LS_RESP: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xrv_mem_arb.sv
// Self-checking bench for xrv_mem_arb. Requesters and an auto-responding
// memory are driven just after each rising edge; a negedge monitor compares
// every bus grant and every response against scoreboard queues filled when
// the stimulus is queued.
module tb_xrv_mem_arb;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ls_hint = 1'b0;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [3:0]  ls_be = 4'h0;
    logic [31:0] ls_addr = 32'h0;
    logic [31:0] ls_wdata = 32'h0;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy, err;

    xrv_mem_arb #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst), .ls_hint(ls_hint), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_if;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    logic [31:0] if_q[$];
    bus_t        ls_q[$];
    bus_t        bus_exp[$];
    logic [31:0] if_exp[$];
    logic [31:0] ls_exp[$];

    int   n_vec = 0;
    int   n_err = 0;
    bit   mem_auto = 1'b0;
    bit   resp_due = 1'b0;
    logic [31:0] resp_data = 32'h0;
    bus_t mon_e;
    logic [31:0] mon_d;

    // Memory contents: one fixed word for the single-fetch case, a simple
    // address scramble everywhere else.
    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
    endfunction

    // Requesters present the head of their queue; auto memory grants at once
    // and responds one cycle later.
    always @(posedge clk) begin
        #1;
        if_req  = (if_q.size() != 0);
        if_addr = if_req ? if_q[0] : 32'h0;
        ls_req  = (ls_q.size() != 0);
        if (ls_req) begin
            ls_we = ls_q[0].we; ls_be = ls_q[0].be;
            ls_addr = ls_q[0].addr; ls_wdata = ls_q[0].wdata;
        end else begin
            ls_we = 1'b0; ls_be = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
        end
        if (mem_auto) begin
            mem_rvalid = resp_due;
            mem_rdata  = resp_due ? resp_data : 32'h0;
            resp_due   = 1'b0;
            if (mem_req === 1'b1) begin
                mem_gnt   = 1'b1;
                resp_due  = 1'b1;
                resp_data = mem_we ? 32'h0 : rd_model(mem_addr);
            end else begin
                mem_gnt = 1'b0;
            end
        end
    end

    // Monitor: grant order/fields and response data against the scoreboard.
    always @(negedge clk) begin
        if (mem_req === 1'b1 && mem_gnt === 1'b1) begin
            n_vec++;
            if (bus_exp.size() == 0) begin
                n_err++;
                $display("FAIL bus_grant: unexpected grant addr=%h we=%b", mem_addr, mem_we);
            end else begin
                mon_e = bus_exp.pop_front();
                if ({if_gnt, ls_gnt, mem_we, mem_be, mem_addr} !==
                        {mon_e.is_if, ~mon_e.is_if, mon_e.we, mon_e.be, mon_e.addr} ||
                    (!mon_e.is_if && mem_wdata !== mon_e.wdata)) begin
                    n_err++;
                    $display("FAIL bus_grant: got if_gnt=%b ls_gnt=%b we=%b be=%h addr=%h wdata=%h, want is_if=%b we=%b be=%h addr=%h wdata=%h",
                             if_gnt, ls_gnt, mem_we, mem_be, mem_addr, mem_wdata,
                             mon_e.is_if, mon_e.we, mon_e.be, mon_e.addr, mon_e.wdata);
                end
            end
        end
        if (if_gnt === 1'b1 && if_q.size() != 0) void'(if_q.pop_front());
        if (ls_gnt === 1'b1 && ls_q.size() != 0) void'(ls_q.pop_front());
        if (if_rvalid === 1'b1) begin
            n_vec++;
            if (if_exp.size() == 0) begin
                n_err++;
                $display("FAIL if_resp: unexpected if_rvalid data=%h", if_rdata);
            end else begin
                mon_d = if_exp.pop_front();
                if (if_rdata !== mon_d) begin
                    n_err++;
                    $display("FAIL if_resp: got %h want %h", if_rdata, mon_d);
                end
            end
        end
        if (ls_rvalid === 1'b1) begin
            n_vec++;
            if (ls_exp.size() == 0) begin
                n_err++;
                $display("FAIL ls_resp: unexpected ls_rvalid data=%h", ls_rdata);
            end else begin
                mon_d = ls_exp.pop_front();
                if (ls_rdata !== mon_d) begin
                    n_err++;
                    $display("FAIL ls_resp: got %h want %h", ls_rdata, mon_d);
                end
            end
        end
    end

    task automatic push_fetch(input logic [31:0] a, input bit expect_data);
        bus_t b;
        b.is_if = 1'b1; b.we = 1'b0; b.be = 4'hF; b.addr = a; b.wdata = 32'h0;
        if_q.push_back(a);
        bus_exp.push_back(b);
        if (expect_data) if_exp.push_back(rd_model(a));
    endtask

    task automatic push_ls(input logic we, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] wd);
        bus_t b;
        b.is_if = 1'b0; b.we = we; b.be = be; b.addr = a; b.wdata = wd;
        ls_q.push_back(b);
        bus_exp.push_back(b);
        ls_exp.push_back(we ? 32'h0 : rd_model(a));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(if_q.size() == 0 && ls_q.size() == 0 && if_exp.size() == 0 &&
                     ls_exp.size() == 0 && busy === 1'b0) && n < 300);
        n_vec++;
        if (busy !== 1'b0 || if_exp.size() != 0 || ls_exp.size() != 0) begin
            n_err++;
            $display("FAIL %s drain: busy=%b if_left=%0d ls_left=%0d after %0d cycles, want all idle",
                     name, busy, if_exp.size(), ls_exp.size(), n);
        end
    endtask

    task automatic wait_mem_req(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_req !== 1'b1 && n < 50);
        n_vec++;
        if (mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL %s wait_mem_req: mem_req=%b want 1 within 50 cycles", name, mem_req);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy, err, mem_req} !== 3'b000) begin
            n_err++; $display("FAIL reset_state: busy/err/mem_req got %b want 000", {busy, err, mem_req});
        end
        n_vec++;
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'h0) begin
            n_err++; $display("FAIL reset_fields: we=%b be=%h addr=%h wdata=%h want all 0",
                              mem_we, mem_be, mem_addr, mem_wdata);
        end
        n_vec++;
        if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 4'b0000) begin
            n_err++; $display("FAIL reset_outputs: gnt/rvalid got %b want 0000",
                              {if_gnt, ls_gnt, if_rvalid, ls_rvalid});
        end
        @(posedge clk); #2;
        rst = 1'b0;
        mem_auto = 1'b1;
    endtask

    task automatic test_single_fetch();
        @(posedge clk); #2;
        push_fetch(32'h100, 1'b1);
        @(posedge clk);
        @(negedge clk);   // cycle 0: request visible, arbiter still idle
        n_vec++;
        if ({mem_req, busy} !== 2'b00) begin
            n_err++; $display("FAIL single_c0: mem_req/busy got %b want 00", {mem_req, busy});
        end
        @(negedge clk);   // cycle 1: bus request out and granted
        n_vec++;
        if ({mem_req, if_gnt, mem_addr} !== {1'b1, 1'b1, 32'h100}) begin
            n_err++; $display("FAIL single_c1: mem_req=%b if_gnt=%b addr=%h want 1 1 00000100",
                              mem_req, if_gnt, mem_addr);
        end
        @(negedge clk);   // cycle 2: response
        n_vec++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL single_c2: if_rvalid=%b data=%h want 1 deadbeef", if_rvalid, if_rdata);
        end
        @(negedge clk);   // cycle 3: back in IDLE
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL single_c3: busy got %b want 0", busy);
        end
        drain("single");
    endtask

    task automatic test_contention();
        @(posedge clk); #2;
        push_ls(1'b1, 4'b0011, 32'h2000, 32'hCAFE_F00D);
        push_fetch(32'h104, 1'b1);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({ls_gnt, if_gnt, mem_we, mem_be} !== {1'b1, 1'b0, 1'b1, 4'b0011}) begin
            n_err++; $display("FAIL contention_first: ls_gnt=%b if_gnt=%b we=%b be=%b want 1 0 1 0011",
                              ls_gnt, if_gnt, mem_we, mem_be);
        end
        drain("contention");
    endtask

    task automatic test_starvation();
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #2;
            for (int i = 0; i < 4; i++)
                push_ls(1'b0, 4'hF, 32'h3000 + 32'(r * 256 + i * 4), 32'h0);
            push_fetch(32'h400 + 32'(r * 4), 1'b1);
            for (int i = 4; i < 6; i++)
                push_ls(1'b0, 4'hF, 32'h3000 + 32'(r * 256 + i * 4), 32'h0);
            drain("starvation");
        end
    endtask

    task automatic test_ls_hint();
        @(posedge clk); #2;
        ls_hint = 1'b1;
        push_fetch(32'h500, 1'b1);
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            n_vec++;
            if ({mem_req, busy} !== 2'b00) begin
                n_err++; $display("FAIL ls_hint_hold: mem_req/busy got %b want 00", {mem_req, busy});
            end
        end
        @(posedge clk); #2;
        ls_hint = 1'b0;
        drain("ls_hint_release");
        // A fetch already latched is not blocked by a later hint.
        @(posedge clk); #2;
        mem_auto = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        push_fetch(32'h504, 1'b1);
        wait_mem_req("ls_hint_latched");
        @(posedge clk); #2;
        ls_hint = 1'b1; mem_gnt = 1'b1;
        @(posedge clk); #2;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd_model(32'h504);
        @(posedge clk); #2;
        mem_rvalid = 1'b0; mem_rdata = 32'h0; ls_hint = 1'b0;
        mem_auto = 1'b1;
        drain("ls_hint_latched");
    endtask

    task automatic test_flush(input bit same_cycle);
        @(posedge clk); #2;
        mem_auto = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        push_fetch(same_cycle ? 32'h308 : 32'h300, 1'b0);
        wait_mem_req("flush");
        if (!same_cycle) begin
            @(posedge clk); #2;
            flush = 1'b1;
            @(posedge clk); #2;
            flush = 1'b0;
        end else begin
            @(posedge clk); #2;
        end
        mem_gnt = 1'b1;
        @(posedge clk); #2;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234;
        flush = same_cycle;
        @(negedge clk);
        n_vec++;
        if ({if_rvalid, busy} !== 2'b01) begin
            n_err++; $display("FAIL flush_resp(same=%0d): if_rvalid/busy got %b want 01",
                              same_cycle, {if_rvalid, busy});
        end
        @(posedge clk); #2;
        mem_rvalid = 1'b0; mem_rdata = 32'h0; flush = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, err} !== 2'b00) begin
            n_err++; $display("FAIL flush_idle(same=%0d): busy/err got %b want 00", same_cycle, {busy, err});
        end
        @(posedge clk); #2;
        mem_auto = 1'b1;
        push_fetch(same_cycle ? 32'h30C : 32'h304, 1'b1);
        drain("flush_followup");
    endtask

    task automatic test_reset_and_err();
        @(posedge clk); #2;
        mem_auto = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        push_ls(1'b0, 4'hF, 32'h600, 32'h0);
        wait_mem_req("rst_mid");
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_busy: busy got %b want 1", busy);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        ls_q.delete(); bus_exp.delete(); ls_exp.delete();
        ls_req = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({mem_req, busy, err} !== 3'b000) begin
            n_err++; $display("FAIL rst_mid: mem_req/busy/err got %b want 000", {mem_req, busy, err});
        end
        @(posedge clk); #2;
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        @(negedge clk);
        n_vec++;
        if ({if_rvalid, ls_rvalid, err} !== 3'b000) begin
            n_err++; $display("FAIL stray_rvalid: if_rvalid/ls_rvalid/err got %b want 000",
                              {if_rvalid, ls_rvalid, err});
        end
        @(posedge clk); #2;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (4) begin
            @(negedge clk);
            n_vec++;
            if (err !== 1'b1) begin
                n_err++; $display("FAIL err_sticky: err got %b want 1", err);
            end
        end
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (err !== 1'b0) begin
            n_err++; $display("FAIL err_cleared: err got %b want 0", err);
        end
        @(posedge clk); #2;
        mem_auto = 1'b1;
        push_fetch(32'h700, 1'b1);
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_ls_hint();
        test_flush(1'b0);
        test_flush(1'b1);
        test_reset_and_err();
        n_vec++;
        if (bus_exp.size() != 0 || if_exp.size() != 0 || ls_exp.size() != 0) begin
            n_err++; $display("FAIL leftovers: bus=%0d if=%0d ls=%0d want 0 0 0",
                              bus_exp.size(), if_exp.size(), ls_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

endmodule
